// File: rtl/riscv_g7_pkg.sv
// Purpose: shared types and constants for the g7 core and its data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_g7_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array_g7.sv
// Purpose: 2^ADDR_WIDTH x 32 word array, byte-enable synchronous write, registered synchronous read.
// Latency: write commits at the enabling edge; read data is valid after the enabling edge.
// Backpressure: none; the read register holds its value until the next read enable.
module dmem_array_g7
    import riscv_g7_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic [XLEN-1:0]       rdata
);

    // Contents are deliberately left unreset.
    logic [XLEN-1:0] mem [2**ADDR_WIDTH];

    // Byte-granular write: only lanes with their strobe bit set are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; the output holds between reads so the response stays stable.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder_g7.sv
// Purpose: data-memory responder for the g7 load/store port; optional access errors under DMEM_G7_ERR_EN.
// Latency: rsp_valid rises WAIT_CYCLES+1 cycles after request acceptance; one-cycle bubble after each response.
// Backpressure: one transaction outstanding; req_ready low until the response handshakes; rsp held while rsp_ready low.
module dmem_responder_g7
    import riscv_g7_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_t           state;
    dmem_state_t           state_nxt;
    logic [3:0]            cnt;
    logic                  run_q;
    logic                  we_q;
    logic                  err_q;
    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [XLEN-1:0]       wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  access;
    logic                  accept;
    logic                  rsp_done;
    logic                  req_err;
    logic                  arr_we;
    logic                  arr_re;
    logic [XLEN-1:0]       arr_rdata;
    logic                  unused_addr;

`ifdef DMEM_G7_ERR_EN
    // Misaligned or beyond the implemented word range.
    assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[XLEN-1:ADDR_WIDTH+2]);
`else
    // Byte offset and upper bits are ignored, so accesses wrap.
    assign req_err = 1'b0;
`endif
    assign unused_addr = ^{req_addr[1:0], req_addr[XLEN-1:ADDR_WIDTH+2]};

    // State register; run_q keeps req_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = run_q;
                if (req_valid && run_q) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = req_valid && req_ready;
    assign rsp_done = rsp_valid && rsp_ready;

    // Request inputs are captured only at the accepting edge; the counter then runs down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            cnt     <= WAIT_INIT;
            we_q    <= req_we;
            err_q   <= req_err;
            idx_q   <= req_addr[ADDR_WIDTH+1:2];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response qualifiers, set at the access edge and cleared by the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ok   <= 1'b0;
            rsp_err <= 1'b0;
        end else if (access) begin
            rd_ok   <= !we_q && !err_q;
            rsp_err <= err_q;
        end else if (rsp_done) begin
            rd_ok   <= 1'b0;
            rsp_err <= 1'b0;
        end
    end

    // Errored accesses never touch the array.
    assign arr_we = access && we_q && !err_q;
    assign arr_re = access && !we_q && !err_q;

    // Stores and errors report zero; loads expose the array's held read register.
    assign rsp_rdata = rd_ok ? arr_rdata : '0;

    dmem_array_g7 #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (idx_q),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder_g7.sv
// Purpose: self-checking bench for dmem_responder_g7 (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Latency: expected response latency is derived from the wait-state parameter.
// Backpressure: randomized rsp_ready stalls; back-to-back cadence checked on the zero-wait instance.
module tb_dmem_responder_g7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [3:0]  req_wstrb0;

    int total = 0;
    int bad   = 0;

    // Reference memory: word index -> contents.
    logic [31:0] mem_m [int];

    always #5 clk = ~clk;

    dmem_responder_g7 #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder_g7 #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_G7_ERR_EN
        return (a % 4 != 0) || (a >= 32'(4 * 1024));
`else
        return (a === 32'hx);
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        int          k;
        if (model_err(a)) return;
        k = model_idx(a);
        w = mem_m.exists(k) ? mem_m[k] : 32'hx;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mem_m[k] = w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a);
        if (model_err(a)) return 32'h0;
        if (!mem_m.exists(model_idx(a))) return 32'hx;
        return mem_m[model_idx(a)];
    endfunction

    // Drives one transaction on the WAIT_CYCLES=2 instance and reports what it saw.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int stall,
                       output logic [31:0] rdata, output logic err, output int lat, output logic stable);
        int n;
        rdata = 32'h0; err = 1'b0; lat = -1; stable = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL accept_timeout req_ready=%b want=1", req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        // Garbage after acceptance must be ignored.
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_timeout rsp_valid=%b want=1", rsp_valid);
            return;
        end
        rdata = rsp_rdata; err = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err || req_ready) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid || !req_ready) stable = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_wstrb0 = 0; rsp_ready0 = 0;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b want=0", rsp_err); end
        total++; if (req_ready0 !== 1'b0) begin bad++; $display("FAIL rst_req_ready0 got=%b want=0", req_ready0); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL release_req_ready got=%b want=0", req_ready); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_edge_req_ready got=%b want=1", req_ready); end
        total++; if (req_ready0 !== 1'b1) begin bad++; $display("FAIL post_edge_req_ready0 got=%b want=1", req_ready0); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er, st; int lat;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st);
        model_store(32'h10, 32'hDEADBEEF, 4'hF);
        total++; if (lat !== 3) begin bad++; $display("FAIL store_latency got=%0d want=3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got=%b want=0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata got=%h want=0", rd); end
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st);
        total++; if (lat !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h want=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", er); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL load_handshake got=%b want=1", st); end
    endtask

    task automatic test_strobes;
        logic [31:0] rd; logic er, st; int lat;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st);
        model_store(32'h20, 32'h11223344, 4'hF);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er, lat, st);
        model_store(32'h20, 32'hAABBCCDD, 4'h5);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_merge got=%h want=11bb33dd", rd); end
        // Zero strobe is a no-op write that still responds.
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, st);
        total++; if (lat !== 3) begin bad++; $display("FAIL nostrb_latency got=%0d want=3", lat); end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
        total++; if (rd !== model_load(32'h20)) begin bad++; $display("FAIL nostrb_rdata got=%h want=%h", rd, model_load(32'h20)); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er, st; int lat;
        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st);
        total++; if (st !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1", st); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_rdata got=%h want=deadbeef", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL bp_latency got=%0d want=3", lat); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er, st; int lat;
        logic [31:0] eaddr [2];
        logic [31:0] edata [2];
        eaddr[0] = 32'h22;   edata[0] = 32'h55555555;
        eaddr[1] = 32'h1000; edata[1] = 32'h77777777;
        txn(1'b1, 32'h0, 32'h01020304, 4'hF, 0, rd, er, lat, st);
        model_store(32'h0, 32'h01020304, 4'hF);
        for (int i = 0; i < 2; i++) begin
            txn(1'b1, eaddr[i], edata[i], 4'hF, 0, rd, er, lat, st);
            model_store(eaddr[i], edata[i], 4'hF);
            total++; if (er !== model_err(eaddr[i])) begin bad++; $display("FAIL err_flag addr=%h got=%b want=%b", eaddr[i], er, model_err(eaddr[i])); end
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_rdata addr=%h got=%h want=0", eaddr[i], rd); end
            total++; if (lat !== 3) begin bad++; $display("FAIL err_latency addr=%h got=%0d want=3", eaddr[i], lat); end
        end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
        total++; if (rd !== model_load(32'h20)) begin bad++; $display("FAIL err_word20 got=%h want=%h", rd, model_load(32'h20)); end
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, st);
        total++; if (rd !== model_load(32'h0)) begin bad++; $display("FAIL err_word0 got=%h want=%h", rd, model_load(32'h0)); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er, st; int lat, n; logic seen;
        txn(1'b1, 32'h30, 32'h12345678, 4'hF, 0, rd, er, lat, st);
        model_store(32'h30, 32'h12345678, 4'hF);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b want=1", req_ready); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0 || req_ready !== 1'b0) seen = 1'b1; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rsp_seen got=%b want=0", seen); end
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, st);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL mid_old_data got=%h want=12345678", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d, exp; logic er, st, we; int lat, stall; logic [3:0] s;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            txn(1'b1, 32'(w * 4), d, 4'hF, 0, rd, er, lat, st);
            model_store(32'(w * 4), d, 4'hF);
        end
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom);
            a = 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 5))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a + 32'($urandom_range(1, 3) * 32'h1000);
                default: ;
            endcase
            d = $urandom; s = 4'($urandom); stall = $urandom_range(0, 3);
            exp = we ? 32'h0 : model_load(a);
            txn(we, a, d, s, stall, rd, er, lat, st);
            if (we) model_store(a, d, s);
            total++; if (rd !== exp) begin bad++; $display("FAIL rnd_rdata t=%0d addr=%h got=%h want=%h", t, a, rd, exp); end
            total++; if (er !== model_err(a)) begin bad++; $display("FAIL rnd_err t=%0d addr=%h got=%b want=%b", t, a, er, model_err(a)); end
            total++; if (lat !== 3) begin bad++; $display("FAIL rnd_latency t=%0d got=%0d want=3", t, lat); end
            total++; if (st !== 1'b1) begin bad++; $display("FAIL rnd_stable t=%0d got=%b want=1", t, st); end
        end
    endtask

    task automatic test_back_to_back;
        int acc_q[$];
        int rsp_q[$];
        int n;
        logic rdbad;
        // Seed one word in the zero-wait instance.
        @(negedge clk);
        n = 0;
        while (!req_ready0 && n < 50) begin @(negedge clk); n++; end
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h40; req_wdata0 = 32'hA5A50F0F; req_wstrb0 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0; rsp_ready0 = 1'b1;
        n = 0;
        while (!rsp_valid0 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        n = 0;
        while (!req_ready0 && n < 20) begin @(negedge clk); n++; end
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h40; req_wstrb0 = 4'h0;
        rdbad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (req_valid0 && req_ready0) acc_q.push_back(c);
            if (rsp_valid0) begin
                rsp_q.push_back(c);
                if (rsp_rdata0 !== 32'hA5A50F0F || rsp_err0 !== 1'b0) rdbad = 1'b1;
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        rsp_ready0 = 1'b0;
        total++; if (acc_q.size() != 5) begin bad++; $display("FAIL b2b_accepts got=%0d want=5", acc_q.size()); end
        total++; if (rsp_q.size() != 5) begin bad++; $display("FAIL b2b_responses got=%0d want=5", rsp_q.size()); end
        total++; if (rdbad !== 1'b0) begin bad++; $display("FAIL b2b_rdata got=%b want=0", rdbad); end
        for (int i = 0; i + 1 < acc_q.size(); i++) begin
            total++;
            if (acc_q[i+1] - acc_q[i] != 3) begin bad++; $display("FAIL b2b_period i=%0d got=%0d want=3", i, acc_q[i+1] - acc_q[i]); end
        end
        for (int i = 0; i < acc_q.size() && i < rsp_q.size(); i++) begin
            total++;
            if (rsp_q[i] - acc_q[i] - 1 != 1) begin bad++; $display("FAIL b2b_latency i=%0d got=%0d want=1", i, rsp_q[i] - acc_q[i] - 1); end
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_strobes;
        test_backpressure;
        test_errors;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
